uart_tx_fifo_ctrl: RTL and testbench

UART_TX_FIFO_CTRL -- requirements
Module: uart_tx_fifo_ctrl

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_fifo_ctrl.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types for the UART block family.
//   uart_tx_ctrl_state_t : state encoding of the TX FIFO-to-serializer controller.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no byte in flight
        ST_WAIT  = 2'd1,   // read issued, FIFO data returns this cycle
        ST_HOLD  = 2'd2,   // byte offered to serializer
        ST_FLUSH = 2'd3    // draining FIFO, all returned data ignored
    } uart_tx_ctrl_state_t;

endpackage

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl
//   Pulls bytes out of the TX FIFO and offers them to the serializer with a
//   valid/ready handshake. Words that come back with a parity error are
//   dropped and counted instead of being sent. A flush discards the held
//   byte and drains the FIFO.
//
// Ports
//   i_clk, i_nrst        : clock (rising edge), async active-low reset
//   i_enable             : permits new FIFO reads (bytes in flight still finish)
//   i_flush              : level, discard held byte and FIFO contents
//   i_cnt_clr            : clear dropped-byte counter
//   o_fifo_rd_req        : FIFO read request
//   i_fifo_empty         : FIFO empty flag
//   i_fifo_valid/data    : read data, valid one cycle after an accepted read
//   i_fifo_parity_error  : parity error, qualified by i_fifo_valid
//   o_tx_valid/o_tx_data : byte offered to serializer
//   i_tx_ready           : serializer accepts byte
//   o_busy               : controller not idle
//   o_parity_drop        : one-cycle pulse per dropped byte
//   o_drop_cnt           : saturating count of dropped bytes
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_enable,
    input  logic             i_flush,
    input  logic             i_cnt_clr,
    output logic             o_fifo_rd_req,
    input  logic             i_fifo_empty,
    input  logic             i_fifo_valid,
    input  logic [DW-1:0]    i_fifo_data,
    input  logic             i_fifo_parity_error,
    output logic             o_tx_valid,
    output logic [DW-1:0]    o_tx_data,
    input  logic             i_tx_ready,
    output logic             o_busy,
    output logic             o_parity_drop,
    output logic [CNT_W-1:0] o_drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    uart_tx_ctrl_state_t state_q, state_d;

    logic rd_req_c;     // read request before reset gating
    logic rd_req_q;     // read request of the previous cycle
    logic tx_valid_c;
    logic load_byte;    // clean word returned in WAIT
    logic drop_byte;    // corrupted word returned in WAIT

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q  <= ST_IDLE;
            rd_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_req_q <= o_fifo_rd_req;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_flush)
                    state_d = ST_FLUSH;
                else if (i_enable && !i_fifo_empty)
                    state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Flush wins over returning data: the word is discarded, not counted.
                if (i_flush)
                    state_d = ST_FLUSH;
                else if (i_fifo_valid && !i_fifo_parity_error)
                    state_d = ST_HOLD;
                else
                    state_d = ST_IDLE;
            end
            ST_HOLD: begin
                // A handshake in the same cycle as flush still completes the byte.
                if (i_tx_ready) begin
                    if (i_enable && !i_fifo_empty && !i_flush)
                        state_d = ST_WAIT;
                    else if (i_flush)
                        state_d = ST_FLUSH;
                    else
                        state_d = ST_IDLE;
                end else if (i_flush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // A read issued last cycle still has data landing now, so wait
                // one quiet cycle after the last read before leaving.
                if (i_fifo_empty && !i_flush && !rd_req_q)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------
    always_comb begin
        rd_req_c   = 1'b0;
        tx_valid_c = 1'b0;
        load_byte  = 1'b0;
        drop_byte  = 1'b0;
        case (state_q)
            ST_IDLE:  rd_req_c = !i_flush && i_enable && !i_fifo_empty;
            ST_WAIT: begin
                load_byte = !i_flush && i_fifo_valid && !i_fifo_parity_error;
                drop_byte = !i_flush && i_fifo_valid &&  i_fifo_parity_error;
            end
            ST_HOLD: begin
                tx_valid_c = 1'b1;
                rd_req_c   = i_tx_ready && i_enable && !i_fifo_empty && !i_flush;
            end
            ST_FLUSH: rd_req_c = !i_fifo_empty;
            default: ;
        endcase
    end

    // IDLE can request a read from inputs alone, so gate with reset to keep
    // the FIFO untouched while reset is held.
    assign o_fifo_rd_req = rd_req_c && i_nrst;
    assign o_tx_valid    = tx_valid_c && i_nrst;
    assign o_busy        = (state_q != ST_IDLE) && i_nrst;

    // ---------------------------------------------------------------
    // Datapath: held byte, drop pulse, saturating drop counter
    // ---------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_tx_data     <= '0;
            o_parity_drop <= 1'b0;
            o_drop_cnt    <= '0;
        end else begin
            if (load_byte)
                o_tx_data <= i_fifo_data;
            o_parity_drop <= drop_byte;
            if (i_cnt_clr)
                o_drop_cnt <= drop_byte ? CNT_ONE : '0;
            else if (drop_byte && (o_drop_cnt != CNT_MAX))
                o_drop_cnt <= o_drop_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb_uart_tx_fifo_ctrl
//   Directed bench: a small FIFO model feeds the controller; inputs change
//   just after the falling edge and outputs are checked 1 ns later.
//   CNT_W is 2 so counter saturation is reachable in a few drops.
module tb_uart_tx_fifo_ctrl;

    localparam int DW    = 8;
    localparam int CNT_W = 2;

    logic             i_clk = 1'b0;
    logic             i_nrst;
    logic             i_enable;
    logic             i_flush;
    logic             i_cnt_clr;
    logic             o_fifo_rd_req;
    logic             i_fifo_empty;
    logic             i_fifo_valid = 1'b0;
    logic [DW-1:0]    i_fifo_data = '0;
    logic             i_fifo_parity_error = 1'b0;
    logic             o_tx_valid;
    logic [DW-1:0]    o_tx_data;
    logic             i_tx_ready;
    logic             o_busy;
    logic             o_parity_drop;
    logic [CNT_W-1:0] o_drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    uart_tx_fifo_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
        .i_clk               (i_clk),
        .i_nrst              (i_nrst),
        .i_enable            (i_enable),
        .i_flush             (i_flush),
        .i_cnt_clr           (i_cnt_clr),
        .o_fifo_rd_req       (o_fifo_rd_req),
        .i_fifo_empty        (i_fifo_empty),
        .i_fifo_valid        (i_fifo_valid),
        .i_fifo_data         (i_fifo_data),
        .i_fifo_parity_error (i_fifo_parity_error),
        .o_tx_valid          (o_tx_valid),
        .o_tx_data           (o_tx_data),
        .i_tx_ready          (i_tx_ready),
        .o_busy              (o_busy),
        .o_parity_drop       (o_parity_drop),
        .o_drop_cnt          (o_drop_cnt)
    );

    // FIFO model: bit 8 of each entry is the parity-error flag.
    logic [8:0] fmem [0:63];
    int  wp = 0;
    int  rp = 0;
    logic bad_rd = 1'b0;

    assign i_fifo_empty = (wp == rp);

    always @(posedge i_clk) begin
        if (o_fifo_rd_req && (wp != rp)) begin
            i_fifo_data         <= fmem[rp][7:0];
            i_fifo_parity_error <= fmem[rp][8];
            i_fifo_valid        <= 1'b1;
            rp                  <= rp + 1;
        end else begin
            i_fifo_valid        <= 1'b0;
            i_fifo_parity_error <= 1'b0;
        end
        if (o_fifo_rd_req && (wp == rp))
            bad_rd <= 1'b1;
    end

    task automatic push(input logic perr, input logic [7:0] d);
        fmem[wp] = {perr, d};
        wp = wp + 1;
    endtask

    task automatic nx();
        @(negedge i_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        i_nrst = 1'b0; i_enable = 1'b1; i_flush = 1'b0;
        i_cnt_clr = 1'b0; i_tx_ready = 1'b1;
        push(1'b0, 8'h55);
        push(1'b0, 8'hA3);

        // Reset state: FIFO non-empty and enabled, yet no read request.
        nx(); #1;
        chk("rst_rd_req",  o_fifo_rd_req, 0);
        chk("rst_tx_valid", o_tx_valid, 0);
        chk("rst_busy",    o_busy, 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_cnt",     o_drop_cnt, 0);
        chk("rst_pdrop",   o_parity_drop, 0);

        // Two bytes back-to-back, ready high: valid every other cycle.
        nx(); i_nrst = 1'b1; #1;
        chk("t1_rd_n0",    o_fifo_rd_req, 1);
        nx(); #1;
        chk("t1_busy_n1",  o_busy, 1);
        chk("t1_valid_n1", o_tx_valid, 0);
        chk("t1_rd_n1",    o_fifo_rd_req, 0);
        nx(); #1;
        chk("t1_valid_n2", o_tx_valid, 1);
        chk("t1_data_n2",  o_tx_data, 8'h55);
        chk("t1_rd_n2",    o_fifo_rd_req, 1);
        nx(); #1;
        chk("t1_valid_n3", o_tx_valid, 0);
        nx(); #1;
        chk("t1_valid_n4", o_tx_valid, 1);
        chk("t1_data_n4",  o_tx_data, 8'hA3);
        chk("t1_rd_n4",    o_fifo_rd_req, 0);
        nx(); #1;
        chk("t1_idle",     o_busy, 0);
        chk("t1_drained",  rp, 2);

        // Backpressure: byte held 10 cycles, no further reads.
        nx(); i_tx_ready = 1'b0; push(1'b0, 8'h3C); #1;
        chk("t2_rd", o_fifo_rd_req, 1);
        nx();
        nx(); push(1'b0, 8'h77); #1;
        chk("t2_valid", o_tx_valid, 1);
        chk("t2_data",  o_tx_data, 8'h3C);
        for (int i = 0; i < 10; i++) begin
            nx(); #1;
            chk("t2_hold_valid", o_tx_valid, 1);
            chk("t2_hold_data",  o_tx_data, 8'h3C);
            chk("t2_hold_rd",    o_fifo_rd_req, 0);
        end
        nx(); i_tx_ready = 1'b1; #1;
        chk("t2_hs_rd", o_fifo_rd_req, 1);
        nx(); #1;
        chk("t2_wait_valid", o_tx_valid, 0);
        nx(); #1;
        chk("t2_valid2", o_tx_valid, 1);
        chk("t2_data2",  o_tx_data, 8'h77);
        chk("t2_rd2",    o_fifo_rd_req, 0);
        nx(); #1;
        chk("t2_idle", o_busy, 0);

        // Parity-corrupted word is dropped and counted.
        nx(); push(1'b1, 8'hEE); #1;
        chk("t3_rd", o_fifo_rd_req, 1);
        nx(); #1;
        chk("t3_valid_w", o_tx_valid, 0);
        chk("t3_pdrop_w", o_parity_drop, 0);
        nx(); #1;
        chk("t3_pdrop",  o_parity_drop, 1);
        chk("t3_cnt",    o_drop_cnt, 1);
        chk("t3_valid",  o_tx_valid, 0);
        nx(); #1;
        chk("t3_pdrop_end", o_parity_drop, 0);
        chk("t3_cnt_end",   o_drop_cnt, 1);
        chk("t3_idle",      o_busy, 0);

        // Flush with a held byte and 3 queued bytes.
        nx(); i_tx_ready = 1'b0; push(1'b0, 8'h11); #1;
        chk("t4_rd", o_fifo_rd_req, 1);
        nx();
        nx(); push(1'b0, 8'h21); push(1'b0, 8'h22); push(1'b0, 8'h23); #1;
        chk("t4_held", o_tx_data, 8'h11);
        nx(); i_flush = 1'b1; #1;
        chk("t4_flush_rd", o_fifo_rd_req, 0);
        nx(); i_flush = 1'b0; #1;
        chk("t4_f0_busy",  o_busy, 1);
        chk("t4_f0_valid", o_tx_valid, 0);
        chk("t4_f0_rd",    o_fifo_rd_req, 1);
        nx(); #1;
        chk("t4_f1_rd",    o_fifo_rd_req, 1);
        chk("t4_f1_valid", o_tx_valid, 0);
        nx(); #1;
        chk("t4_f2_rd",    o_fifo_rd_req, 1);
        nx(); #1;
        chk("t4_f3_rd",    o_fifo_rd_req, 0);
        chk("t4_f3_busy",  o_busy, 1);
        nx(); #1;
        chk("t4_f4_busy",  o_busy, 1);
        chk("t4_f4_valid", o_tx_valid, 0);
        nx(); #1;
        chk("t4_idle",  o_busy, 0);
        chk("t4_valid", o_tx_valid, 0);
        chk("t4_cnt",   o_drop_cnt, 1);
        chk("t4_drained", rp, 9);

        // Three more drops: 1 + 3 saturates a 2-bit counter at 3.
        nx(); i_tx_ready = 1'b1;
        push(1'b1, 8'h01); push(1'b1, 8'h02); push(1'b1, 8'h03); #1;
        chk("t5_rd", o_fifo_rd_req, 1);
        repeat (6) nx();
        #1;
        chk("t5_sat",   o_drop_cnt, 3);
        chk("t5_pdrop", o_parity_drop, 1);
        // Clear coinciding with a fifth drop leaves 1.
        nx(); push(1'b1, 8'h04); #1;
        chk("t5_rd2", o_fifo_rd_req, 1);
        nx(); i_cnt_clr = 1'b1; #1;
        nx(); i_cnt_clr = 1'b0; #1;
        chk("t5_clr_inc", o_drop_cnt, 1);
        chk("t5_pdrop2",  o_parity_drop, 1);

        // Reset asserted while holding a byte.
        nx(); i_tx_ready = 1'b0; push(1'b0, 8'h5A); #1;
        chk("t6_rd", o_fifo_rd_req, 1);
        nx();
        nx(); #1;
        chk("t6_hold", o_tx_valid, 1);
        nx(); i_nrst = 1'b0; #1;
        chk("t6_rst_valid", o_tx_valid, 0);
        chk("t6_rst_busy",  o_busy, 0);
        chk("t6_rst_data",  o_tx_data, 0);
        chk("t6_rst_cnt",   o_drop_cnt, 0);
        push(1'b0, 8'h6B); #1;
        chk("t6_rst_rd", o_fifo_rd_req, 0);
        nx(); i_nrst = 1'b1; i_tx_ready = 1'b1; #1;
        chk("t6_rd2", o_fifo_rd_req, 1);
        nx();
        nx(); #1;
        chk("t6_valid2", o_tx_valid, 1);
        chk("t6_data2",  o_tx_data, 8'h6B);
        chk("t6_pdrop",  o_parity_drop, 0);
        chk("t6_cnt",    o_drop_cnt, 0);
        nx(); #1;
        chk("t6_idle", o_busy, 0);

        // Enable low blocks new reads but not a byte already in flight.
        nx(); i_enable = 1'b0; push(1'b0, 8'h99); #1;
        chk("t7_rd_off", o_fifo_rd_req, 0);
        nx(); #1;
        chk("t7_rd_off2", o_fifo_rd_req, 0);
        chk("t7_busy",    o_busy, 0);
        nx(); i_enable = 1'b1; #1;
        chk("t7_rd_on", o_fifo_rd_req, 1);
        nx(); i_enable = 1'b0; #1;
        chk("t7_wait_busy", o_busy, 1);
        nx(); #1;
        chk("t7_valid", o_tx_valid, 1);
        chk("t7_data",  o_tx_data, 8'h99);
        chk("t7_rd",    o_fifo_rd_req, 0);
        nx(); #1;
        chk("t7_idle", o_busy, 0);

        chk("no_rd_when_empty", bad_rd, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
